// File: rtl/alarm_sequencer.sv
// Alarm ring sequencer: detects the alarm minute, rings with an on/off beep cadence,
// and handles stop, limited snooze and an automatic ring timeout.
module alarm_sequencer #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned BEEP_ON_MS     = 500,
  parameter int unsigned BEEP_OFF_MS    = 500,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZES    = 3,
  localparam int unsigned SnzW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [4:0]      cur_hour,
  input  logic [5:0]      cur_min,
  input  logic [5:0]      cur_sec,
  input  logic [4:0]      alarm_hour,
  input  logic [5:0]      alarm_min,
  input  logic            alarm_enable,
  input  logic            stop_pulse,
  input  logic            snooze_pulse,
  output logic            alarm_trigger,
  output logic            ringing,
  output logic            snoozing,
  output logic [SnzW-1:0] snooze_count
);

  localparam int unsigned OnCyc  = CLK_FREQ / 1000 * BEEP_ON_MS;
  localparam int unsigned PerCyc = CLK_FREQ / 1000 * (BEEP_ON_MS + BEEP_OFF_MS);
  localparam int unsigned SecMax = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int unsigned TickW  = $clog2(CLK_FREQ);
  localparam int unsigned BeepW  = $clog2(PerCyc + 1);
  localparam int unsigned SecW   = $clog2(SecMax + 1);

  localparam logic [TickW-1:0] TickLast = TickW'(CLK_FREQ - 1);
  localparam logic [BeepW-1:0] BeepLast = BeepW'(PerCyc - 1);
  localparam logic [BeepW-1:0] OnLim    = BeepW'(OnCyc);
  localparam logic [SecW-1:0]  RingSecs = SecW'(RING_TIMEOUT_S);
  localparam logic [SecW-1:0]  SnzSecs  = SecW'(SNOOZE_S);
  localparam logic [SnzW-1:0]  SnzMax   = SnzW'(MAX_SNOOZES);

  typedef enum logic [1:0] {StIdle, StRinging, StSnooze} state_e;

  state_e           state_q, state_d;
  logic             match, match_q, fire;
  logic [TickW-1:0] tick_q, tick_d;
  logic [BeepW-1:0] beep_q, beep_d;
  logic [SecW-1:0]  sec_q, sec_d, sec_inc;
  logic [SnzW-1:0]  snz_q, snz_d;
  logic             sec_tick, snooze_ok, ring_done, snz_done;

  assign match     = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
  assign fire      = match && !match_q;
  assign sec_tick  = (tick_q == TickLast);
  assign sec_inc   = sec_q + SecW'(1);
  // Expiry fires on the edge that would complete the final second.
  assign ring_done = sec_tick && (sec_inc == RingSecs);
  assign snz_done  = sec_tick && (sec_inc == SnzSecs);
  assign snooze_ok = snooze_pulse && (snz_q < SnzMax);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      match_q <= 1'b1;  // no fire when reset is released inside the match second
    end else begin
      state_q <= state_d;
      match_q <= match;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fire && alarm_enable) state_d = StRinging;
      end
      StRinging: begin
        if (!alarm_enable || stop_pulse) state_d = StIdle;
        else if (snooze_ok)              state_d = StSnooze;
        else if (ring_done)              state_d = StIdle;
      end
      StSnooze: begin
        if (!alarm_enable || stop_pulse) state_d = StIdle;
        else if (snz_done)               state_d = StRinging;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tick_d = '0;
    beep_d = '0;
    sec_d  = '0;
    snz_d  = snz_q;
    if (state_d == StIdle) begin
      snz_d = '0;
    end else if (state_q == StRinging && state_d == StSnooze) begin
      snz_d = snz_q + SnzW'(1);
    end
    if (state_d == state_q && state_q != StIdle) begin
      tick_d = sec_tick ? '0 : tick_q + TickW'(1);
      sec_d  = sec_tick ? sec_inc : sec_q;
      if (state_q == StRinging) begin
        beep_d = (beep_q == BeepLast) ? '0 : beep_q + BeepW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
      beep_q <= '0;
      sec_q  <= '0;
      snz_q  <= '0;
    end else begin
      tick_q <= tick_d;
      beep_q <= beep_d;
      sec_q  <= sec_d;
      snz_q  <= snz_d;
    end
  end

  always_comb begin
    alarm_trigger = (state_q == StRinging) && (beep_q < OnLim);
    ringing       = (state_q == StRinging);
    snoozing      = (state_q == StSnooze);
    snooze_count  = snz_q;
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Randomised scenario bench for alarm_sequencer against an elapsed-time reference model.
module tb_alarm_sequencer;

  localparam int unsigned F = 1000, ONMS = 200, OFFMS = 300, RT = 3, SZ = 2, MAXS = 2;
  localparam int ON_C  = F / 1000 * ONMS;
  localparam int PER_C = F / 1000 * (ONMS + OFFMS);

  logic       clk = 1'b0, reset_n = 1'b0;
  logic [4:0] cur_hour = '0, alarm_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = 6'd1, alarm_min = '0;
  logic       alarm_enable = 1'b0, stop_pulse = 1'b0, snooze_pulse = 1'b0;
  logic       alarm_trigger, ringing, snoozing;
  logic [1:0] snooze_count;

  int checks = 0, errors = 0;

  alarm_sequencer #(
    .CLK_FREQ(F), .BEEP_ON_MS(ONMS), .BEEP_OFF_MS(OFFMS),
    .RING_TIMEOUT_S(RT), .SNOOZE_S(SZ), .MAX_SNOOZES(MAXS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_enable(alarm_enable),
    .stop_pulse(stop_pulse), .snooze_pulse(snooze_pulse),
    .alarm_trigger(alarm_trigger), .ringing(ringing), .snoozing(snoozing),
    .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  // Reference model: current mode plus cycles elapsed in it.
  typedef enum {MIdle, MRing, MSnooze} mode_e;
  mode_e m_mode;
  int    m_t, m_snz;
  bit    m_prev;

  task automatic m_reset();
    m_mode = MIdle; m_t = 0; m_snz = 0; m_prev = 1'b1;
  endtask

  task automatic m_step();
    bit match, fire;
    if (!reset_n) begin
      m_reset();
      return;
    end
    match  = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 0);
    fire   = match && !m_prev;
    m_prev = match;
    case (m_mode)
      MIdle: begin
        m_snz = 0;
        if (fire && alarm_enable) begin m_mode = MRing; m_t = 0; end
      end
      MRing: begin
        if (!alarm_enable || stop_pulse) begin m_mode = MIdle; m_t = 0; m_snz = 0; end
        else if (snooze_pulse && m_snz < MAXS) begin m_mode = MSnooze; m_t = 0; m_snz++; end
        else if (m_t + 1 == RT * F) begin m_mode = MIdle; m_t = 0; m_snz = 0; end
        else m_t++;
      end
      MSnooze: begin
        if (!alarm_enable || stop_pulse) begin m_mode = MIdle; m_t = 0; m_snz = 0; end
        else if (m_t + 1 == SZ * F) begin m_mode = MRing; m_t = 0; end
        else m_t++;
      end
      default: m_reset();
    endcase
  endtask

  function automatic logic [4:0] m_out();
    logic trig;
    trig = (m_mode == MRing) && ((m_t % PER_C) < ON_C);
    return {trig, m_mode == MRing, m_mode == MSnooze, 2'(m_snz)};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic start_ring();
    alarm_hour   = 5'($urandom_range(0, 23));
    alarm_min    = 6'($urandom_range(0, 59));
    cur_hour     = alarm_hour;
    cur_min      = alarm_min;
    alarm_enable = 1'b1;
    cur_sec      = 6'd59;
    tick();
    cur_sec = 6'd0;
    tick();
  endtask

  task automatic test_reset();
    m_reset();
    #1;
    checks++;
    if ({alarm_trigger, ringing, snoozing, snooze_count} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000",
               {alarm_trigger, ringing, snoozing, snooze_count});
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_match_timeout();
    logic trig_tr[3100];
    logic ring_tr[3100];
    int hi, rc;
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_enable = 1'b1;
    cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
    tick();
    cur_min = 6'd30; cur_sec = 6'd0;
    tick();
    checks++;
    if (alarm_trigger !== 1'b1 || ringing !== 1'b1) begin
      errors++;
      $display("FAIL rise_latency got trig=%b ring=%b exp 1 1", alarm_trigger, ringing);
    end
    for (int i = 0; i < 3100; i++) begin
      trig_tr[i] = alarm_trigger;
      ring_tr[i] = ringing;
      checks++;
      if ({alarm_trigger, ringing, snoozing, snooze_count} !== m_out()) begin
        errors++;
        $display("FAIL match_model cyc %0d got %b exp %b", i,
                 {alarm_trigger, ringing, snoozing, snooze_count}, m_out());
      end
      tick();
    end
    hi = 0; rc = 0;
    for (int i = 0; i < PER_C; i++) hi += int'(trig_tr[i]);
    for (int i = 0; i < 3100; i++) rc += int'(ring_tr[i]);
    checks++;
    if (hi != 200 || trig_tr[199] !== 1'b1 || trig_tr[200] !== 1'b0 || trig_tr[500] !== 1'b1) begin
      errors++;
      $display("FAIL cadence got hi=%0d t199=%b t200=%b t500=%b exp 200 1 0 1",
               hi, trig_tr[199], trig_tr[200], trig_tr[500]);
    end
    checks++;
    if (rc != 3000 || ring_tr[2999] !== 1'b1 || ring_tr[3000] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_len got %0d exp 3000", rc);
    end
  endtask

  task automatic test_snooze_limit();
    int sn;
    start_ring();
    for (int i = 0; i < 250; i++) tick();
    snooze_pulse = 1'b1;
    tick();
    snooze_pulse = 1'b0;
    checks++;
    if ({alarm_trigger, ringing, snoozing, snooze_count} !== 5'b00101) begin
      errors++;
      $display("FAIL snooze_entry got %b exp 00101",
               {alarm_trigger, ringing, snoozing, snooze_count});
    end
    sn = 0;
    for (int i = 0; i < 2500 && snoozing; i++) begin
      sn++;
      checks++;
      if ({alarm_trigger, ringing, snoozing, snooze_count} !== m_out()) begin
        errors++;
        $display("FAIL snooze_model cyc %0d got %b exp %b", i,
                 {alarm_trigger, ringing, snoozing, snooze_count}, m_out());
      end
      tick();
    end
    checks++;
    if (sn != 2000 || alarm_trigger !== 1'b1 || ringing !== 1'b1) begin
      errors++;
      $display("FAIL snooze_len got %0d trig=%b exp 2000 trig=1", sn, alarm_trigger);
    end
    for (int i = 0; i < 10; i++) tick();
    snooze_pulse = 1'b1;
    tick();
    snooze_pulse = 1'b0;
    checks++;
    if (snooze_count !== 2'd2 || snoozing !== 1'b1) begin
      errors++;
      $display("FAIL second_snooze got cnt=%0d snz=%b exp 2 1", snooze_count, snoozing);
    end
    for (int i = 0; i < 2500 && !ringing; i++) tick();
    snooze_pulse = 1'b1;
    tick();
    snooze_pulse = 1'b0;
    checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_count !== 2'd2) begin
      errors++;
      $display("FAIL snooze_limit got ring=%b snz=%b cnt=%0d exp 1 0 2",
               ringing, snoozing, snooze_count);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({alarm_trigger, ringing, snoozing, snooze_count} !== m_out()) begin
        errors++;
        $display("FAIL limit_model cyc %0d got %b exp %b", i,
                 {alarm_trigger, ringing, snoozing, snooze_count}, m_out());
      end
    end
    stop_pulse = 1'b1;
    tick();
    stop_pulse = 1'b0;
  endtask

  task automatic test_simultaneous();
    start_ring();
    for (int i = 0; i < int'($urandom_range(10, 400)); i++) tick();
    snooze_pulse = 1'b1;
    tick();
    snooze_pulse = 1'b0;
    for (int i = 0; i < 2500 && !ringing; i++) tick();
    tick();
    stop_pulse = 1'b1; snooze_pulse = 1'b1;
    tick();
    stop_pulse = 1'b0; snooze_pulse = 1'b0;
    checks++;
    if ({alarm_trigger, ringing, snoozing, snooze_count} !== 5'b0 || m_out() !== 5'b0) begin
      errors++;
      $display("FAIL stop_and_snooze got %b exp 00000",
               {alarm_trigger, ringing, snoozing, snooze_count});
    end
    start_ring();
    tick();
    snooze_pulse = 1'b1;
    tick();
    snooze_pulse = 1'b0;
    for (int i = 0; i < int'($urandom_range(10, 1500)); i++) tick();
    alarm_enable = 1'b0;
    tick();
    checks++;
    if ({alarm_trigger, ringing, snoozing, snooze_count} !== 5'b0) begin
      errors++;
      $display("FAIL disable_in_snooze got %b exp 00000",
               {alarm_trigger, ringing, snoozing, snooze_count});
    end
    alarm_enable = 1'b1;
  endtask

  task automatic test_mid_ring_reset();
    start_ring();
    for (int i = 0; i < 100; i++) tick();
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if ({alarm_trigger, ringing, snoozing, snooze_count} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_ring got %b exp 00000",
               {alarm_trigger, ringing, snoozing, snooze_count});
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({alarm_trigger, ringing, snoozing, snooze_count} !== m_out() || ringing !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc %0d got %b exp %b", i,
                 {alarm_trigger, ringing, snoozing, snooze_count}, m_out());
      end
    end
  endtask

  task automatic test_disarmed();
    alarm_enable = 1'b0;
    cur_sec = 6'd59;
    tick();
    cur_sec = 6'd0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (ringing !== 1'b0 || alarm_trigger !== 1'b0) begin
      errors++;
      $display("FAIL disarmed_match got ring=%b trig=%b exp 0 0", ringing, alarm_trigger);
    end
    cur_sec = 6'd5;
    tick();
    alarm_enable = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (ringing !== 1'b0 || m_out() !== 5'b0) begin
      errors++;
      $display("FAIL late_enable got ring=%b exp 0", ringing);
    end
  endtask

  task automatic test_random();
    alarm_hour = 5'($urandom_range(0, 23));
    alarm_min  = 6'($urandom_range(0, 59));
    cur_hour = alarm_hour; cur_min = alarm_min; cur_sec = 6'd1;
    alarm_enable = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      cur_sec      = (i % 700 == 0) ? 6'($urandom_range(1, 59)) : 6'd0;
      stop_pulse   = ($urandom_range(0, 1999) == 0);
      snooze_pulse = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2999) == 0) alarm_enable = 1'b0;
      else if (!alarm_enable && $urandom_range(0, 99) == 0) alarm_enable = 1'b1;
      tick();
      checks++;
      if ({alarm_trigger, ringing, snoozing, snooze_count} !== m_out()) begin
        errors++;
        $display("FAIL random_model cyc %0d got %b exp %b", i,
                 {alarm_trigger, ringing, snoozing, snooze_count}, m_out());
      end
    end
    stop_pulse = 1'b0;
    snooze_pulse = 1'b0;
  endtask

  initial begin
    test_reset();
    test_match_timeout();
    test_snooze_limit();
    test_simultaneous();
    test_mid_ring_reset();
    test_disarmed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

- Generates the `alarm_trigger` enable consumed by the tone generator `sound_interface`.
- Watches the running clock time against the programmed alarm time and starts a ring episode on a match.
- During a ring episode it gates `alarm_trigger` with a fixed on/off beep cadence.
- Handles stop, snooze (with a limit) and an automatic ring timeout.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: clock frequency in Hz. Must be a multiple of 1000.
- `BEEP_ON_MS`, 500: cadence on-time in ms.
- `BEEP_OFF_MS`, 500: cadence off-time in ms.
- `RING_TIMEOUT_S`, 60: seconds of ringing before automatic stop.
- `SNOOZE_S`, 300: snooze duration in seconds.
- `MAX_SNOOZES`, 3: snooze requests honoured per alarm. 0 disables snooze.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cur_hour`  in  5: current hour, 0–23.
- `cur_min`  in  6: current minute, 0–59.
- `cur_sec`  in  6: current second, 0–59.
- `alarm_hour`  in  5: programmed alarm hour.
- `alarm_min`  in  6: programmed alarm minute.
- `alarm_enable`  in  1: level; alarm armed while high.
- `stop_pulse`  in  1: one-cycle, debounced, synchronous stop request.
- `snooze_pulse`  in  1: one-cycle, debounced, synchronous snooze request.
- `alarm_trigger`  out  1: drives `sound_interface.alarm_trigger`.
- `ringing`  out  1: high in RINGING.
- `snoozing`  out  1: high in SNOOZE.
- `snooze_count`  out  $clog2(MAX_SNOOZES+1): snoozes taken in the current alarm.

## Operation
Derived constants:
- ON_CYC = CLK_FREQ/1000*BEEP_ON_MS.
- PER_CYC = CLK_FREQ/1000*(BEEP_ON_MS+BEEP_OFF_MS).

Match detection:
- `match` = (cur_hour==alarm_hour) && (cur_min==alarm_min) && (cur_sec==0).
- `match_q` is the registered copy of `match`.
- `fire` = `match` && !`match_q`.
- `match_q` resets to 1, so releasing reset inside the match second does not fire.

Counters:
- `beep_cnt` counts 0..PER_CYC-1 and wraps.
- `tick_cnt` counts 0..CLK_FREQ-1 and produces a one-second tick on wrap.
- `sec_cnt` counts seconds.
- All three are cleared on every state entry and advance only in RINGING/SNOOZE.
- `beep_cnt` advances only in RINGING.

States (reset: IDLE):
- IDLE:
  - `snooze_count` := 0.
  - `fire` && `alarm_enable` → RINGING.
- RINGING:
  - !`alarm_enable` → IDLE.
  - else `stop_pulse` → IDLE.
  - else `snooze_pulse` && `snooze_count` < MAX_SNOOZES → SNOOZE, `snooze_count`+1.
  - else `sec_cnt` reaching RING_TIMEOUT_S → IDLE.
  - A `snooze_pulse` with the limit reached is ignored; ringing continues.
- SNOOZE:
  - !`alarm_enable` → IDLE.
  - else `stop_pulse` → IDLE.
  - else `sec_cnt` reaching SNOOZE_S → RINGING.
  - `snooze_pulse` is ignored.
- `fire` is ignored outside IDLE.
- Priority when events coincide: disable > stop > snooze > timeout/expiry.

Outputs (all decoded from registers, no input-to-output combinational path):
- `alarm_trigger` = RINGING && `beep_cnt` < ON_CYC.
- `ringing` = RINGING.
- `snoozing` = SNOOZE.

## Timing
Reset:
- Asserting `reset_n` low immediately forces IDLE and clears all counters.
- While in reset: `alarm_trigger`, `ringing`, `snoozing` and `snooze_count` = 0.
- Reset mid-ring or mid-snooze aborts with no residual output.

Ring entry:
- `fire` sampled at edge E moves the block to RINGING at E.
- `alarm_trigger` and `ringing` are high in the cycle after E (one cycle of latency from the inputs).

Beep cadence:
- `alarm_trigger` is high for ON_CYC cycles, then low for PER_CYC−ON_CYC cycles, repeating.
- Every entry into RINGING restarts the cadence at the on-phase.

Ring timeout:
- RINGING lasts exactly RING_TIMEOUT_S*CLK_FREQ cycles if no other event occurs.

Snooze:
- SNOOZE lasts exactly SNOOZE_S*CLK_FREQ cycles, then RINGING resumes with the cadence restarted.

Stop and snooze response:
- `stop_pulse` or `snooze_pulse` at edge E drops `alarm_trigger` in the cycle after E.

## Test plan
All scenarios use `CLK_FREQ`=1000, `BEEP_ON_MS`=200, `BEEP_OFF_MS`=300, `RING_TIMEOUT_S`=3, `SNOOZE_S`=2, `MAX_SNOOZES`=2.

- **Reset and match:** reset, then set 07:30:00 on the current-time inputs with alarm 07:30 enabled.
  - `alarm_trigger` rises one cycle later.
  - It is then high 200 cycles, low 300 cycles, and repeats.
- **Timeout:** no buttons pressed.
  - `ringing` falls exactly 3000 cycles after entry.
  - The block returns to IDLE with no re-fire while `cur_sec` stays 0.
- **Snooze and limit:** `snooze_pulse` at cycle 250 of ringing.
  - `snoozing`=1 for 2000 cycles, then ringing restarts with `alarm_trigger` high.
  - A second snooze gives `snooze_count`=2.
  - A third `snooze_pulse` is ignored.
- **Simultaneous events:** `stop_pulse` and `snooze_pulse` in the same cycle → IDLE, `snooze_count`=0. In a separate run, dropping `alarm_enable` during SNOOZE → IDLE.
- **Mid-ring reset:** pulse `reset_n` low at cycle 100 of the on-phase.
  - All outputs are 0 immediately.
  - Releasing reset while the match is still held gives no ring.
- **Disarmed match:** with `alarm_enable`=0, a match second gives no ring. Enabling during `cur_sec`=5 of the match minute also gives no ring.
